pc_sequencer_16bit: RTL and testbench
=====================================

# pc_sequencer_16bit

16-bit program-counter sequencer that consumes the combinational `increment_16bit` result (`incA`, `overflow`) and turns it into a registered fetch-address stream. It sits directly downstream of the incrementer and upstream of instruction memory. It holds the current PC, presents it to memory with a valid/ready handshake, and advances on each accepted fetch. It also handles jumps, halts, and the increment-overflow condition.

## Interface
Parameters:
- `RESET_ADDR`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse; leaves IDLE and begins fetching.
- `halt_req`  in  1: request to stop fetching; honoured in RUN.
- `addr_valid`  out  1: `addr` holds a fetch request.
- `addr_ready`  in  1: memory accepts `addr` this cycle.
- `addr`  out  16: current PC, the fetch address.
- `jump_valid`  in  1: load `jump_addr` as the next PC.
- `jump_addr`  in  16: jump target.
- `running`  out  1: high while in RUN.
- `trap`  out  1: sticky; high once the overflow trap has fired (see Configuration).
- `fetch_count`  out  16: number of accepted fetches since reset; saturates at 16'hFFFF.

## Operation
- Internal instance of `increment_16bit`: `A = pc`. Its outputs `incA`/`overflow` form the next-sequential PC and its flag. `overflow` asserts when incrementing 16'h7FFF (signed overflow to 16'h8000).
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → HALT on `halt_req` or trap.
  - HALT → RUN on `start`, unless `trap` is set. A trap makes HALT terminal until reset.
- `addr_valid` = (state == RUN). `addr` = `pc` in all states.
- Accept condition: `addr_valid & addr_ready`.
- Next-PC priority in RUN, highest first:
  1. `jump_valid`: `pc <= jump_addr`.
  2. Accept: `pc <= incA`.
  3. Otherwise: hold.
- Jump with a simultaneous accept: the current address counts as accepted and `fetch_count` increments. The next PC is still `jump_addr`, not `incA`.
- Jump without an accept: the pending address is dropped. This is the only case where `addr` changes while `addr_valid & !addr_ready`.
- `jump_valid` in IDLE or HALT: loads `pc`, no fetch is issued. This allows a start vector to be set before `start`.
- `halt_req` together with an accept in the same cycle: the accept completes (PC advances, count increments), then the next state is HALT.
- `start` while in RUN: ignored.
- `fetch_count` increments by 1 per accept and holds at 16'hFFFF.

## Timing
- Reset values (asynchronous): state=IDLE, `pc`=`RESET_ADDR`, `addr`=`RESET_ADDR`, `addr_valid`=0, `running`=0, `trap`=0, `fetch_count`=0.
- Reset asserted mid-operation forces these values immediately, regardless of handshake state. A pending fetch is abandoned.
- `start` at edge N: `addr_valid`=1 after edge N.
- With `addr_ready` held high, throughput is one address per cycle: PC, PC+1, PC+2, …
- Jump latency: `jump_valid` sampled at edge N, `addr`=`jump_addr` after edge N.
- Halt latency: `addr_valid` falls after the edge that samples `halt_req`.
- All outputs are registered except `addr_valid` and `running`, which are decoded from state registers (no input-to-output combinational path).

## Configuration
- Macro `PC_OVERFLOW_TRAP_EN`.
- Defined: an accept while the incrementer's `overflow`=1 (pc=16'h7FFF) sets `trap`. The PC does not advance; it stays 16'h7FFF. The accept is still counted, and the FSM enters HALT (terminal until reset). A jump in that same cycle wins: no trap, and `pc <= jump_addr`.
- Undefined: `overflow` is ignored, the PC advances 16'h7FFF → 16'h8000 → … → 16'hFFFF → 16'h0000 (unsigned wrap), and `trap` is tied to 0.

## Test plan
- Reset, `start`, `addr_ready`=1 for 4 cycles → `addr` = 0000, 0001, 0002, 0003; `fetch_count`=4.
- `addr_ready`=0 for 3 cycles mid-stream at `pc`=0005 → `addr` holds 0005, count unchanged; raising `addr_ready` resumes at 0006.
- `jump_valid`, `jump_addr`=0x1234 with a simultaneous accept at `pc`=0002 → count +1, next `addr`=0x1234. Then `halt_req` → `addr_valid`=0 next cycle; `start` → resumes at 0x1235 after one accept.
- Jump to 0x7FFE, `addr_ready`=1, with macro defined → accepts 7FFE and 7FFF, then `trap`=1, HALT, `addr`=7FFF; `start` is ignored. Without the macro → stream 7FFE, 7FFF, 8000.
- Jump to 0xFFFF, accept, macro undefined → next `addr`=0000.
- Assert `rst` asynchronously mid-cycle during RUN → all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer_16bit.sv
// rtl/pc_sequencer_16bit.sv - 16-bit program-counter sequencer driving an instruction-fetch handshake
// Optional feature macro: PC_OVERFLOW_TRAP_EN (accept at pc=16'h7FFF traps and halts instead of wrapping)

module increment_16bit (
    input  logic [15:0] A,
    output logic [15:0] incA,
    output logic        overflow
);
    // Next-sequential value; overflow marks the signed 7FFF -> 8000 crossing
    always_comb begin
        incA     = A + 16'd1;
        overflow = (A == 16'h7FFF);
    end
endmodule

module pc_sequencer_16bit #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        addr_valid,
    input  logic        addr_ready,
    output logic [15:0] addr,
    input  logic        jump_valid,
    input  logic [15:0] jump_addr,
    output logic        running,
    output logic        trap,
    output logic [15:0] fetch_count
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        trap_q, trap_d;

    logic [15:0] inc_pc;
    logic        inc_overflow;
    logic        trap_en;
    logic        accept;
    logic        trap_fire;

    increment_16bit u_inc (
        .A        (pc_q),
        .incA     (inc_pc),
        .overflow (inc_overflow)
    );

`ifdef PC_OVERFLOW_TRAP_EN
    assign trap_en = 1'b1;
`else
    assign trap_en = 1'b0;
`endif

    // Handshake decode; a jump in the same cycle suppresses the trap
    assign accept    = (state_q == ST_RUN) & addr_ready;
    assign trap_fire = trap_en & accept & inc_overflow & ~jump_valid;

    // Next-state, next-PC, counter and trap computation
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        trap_d        = trap_q | trap_fire;

        if (accept && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (jump_valid) pc_d = jump_addr;
                if (start)      state_d = ST_RUN;
            end
            ST_RUN: begin
                if (jump_valid) begin
                    pc_d = jump_addr;
                end else if (accept && !trap_fire) begin
                    pc_d = inc_pc;
                end
                if (halt_req || trap_fire) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (jump_valid)          pc_d = jump_addr;
                if (start && !trap_q)    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_ADDR;
            fetch_count_q <= 16'h0000;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            trap_q        <= trap_d;
        end
    end

    assign addr_valid  = (state_q == ST_RUN);
    assign running     = (state_q == ST_RUN);
    assign addr        = pc_q;
    assign fetch_count = fetch_count_q;
    assign trap        = trap_q;
endmodule

// File: tb/tb_pc_sequencer_16bit.sv
// tb/tb_pc_sequencer_16bit.sv - randomized and directed checks of pc_sequencer_16bit against a behavioural model

module tb_pc_sequencer_16bit;
`ifdef PC_OVERFLOW_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        addr_ready = 1'b0;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic        addr_valid;
    logic [15:0] addr;
    logic        running;
    logic        trap;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    pc_sequencer_16bit #(.RESET_ADDR(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .addr        (addr),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .running     (running),
        .trap        (trap),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = stopped before start, 1 = fetching, 2 = halted
    typedef struct packed {
        logic [1:0]  mode;
        logic        trp;
        logic [15:0] pc;
        logic [15:0] cnt;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic st, logic hr, logic rdy,
                                           logic jv, logic [15:0] ja);
        mstate_t n = s;
        int      pcv;
        if (s.mode == 2'd1) begin
            if (rdy) n.cnt = (s.cnt == 16'hFFFF) ? s.cnt : 16'(int'(s.cnt) + 1);
            if (jv) begin
                n.pc = ja;
                if (hr) n.mode = 2'd2;
            end else if (rdy && TRAP_EN && s.pc == 16'h7FFF) begin
                n.trp  = 1'b1;
                n.mode = 2'd2;
            end else begin
                if (rdy) begin
                    pcv  = (int'(s.pc) + 1) % 65536;
                    n.pc = 16'(pcv);
                end
                if (hr) n.mode = 2'd2;
            end
        end else begin
            if (jv) n.pc = ja;
            if (st && !(s.mode == 2'd2 && s.trp)) n.mode = 2'd1;
        end
        return n;
    endfunction

    // Reference model advances on the same edges as the design
    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{mode: 2'd0, trp: 1'b0, pc: 16'h0000, cnt: 16'h0000};
        else     m <= model_next(m, start, halt_req, addr_ready, jump_valid, jump_addr);
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            checks = checks + 5;
            if (addr !== m.pc) begin
                errors++; $display("FAIL model_addr actual=%h expected=%h t=%0t", addr, m.pc, $time);
            end
            if (addr_valid !== (m.mode == 2'd1)) begin
                errors++; $display("FAIL model_valid actual=%b expected=%b t=%0t", addr_valid, m.mode == 2'd1, $time);
            end
            if (running !== (m.mode == 2'd1)) begin
                errors++; $display("FAIL model_running actual=%b expected=%b t=%0t", running, m.mode == 2'd1, $time);
            end
            if (trap !== m.trp) begin
                errors++; $display("FAIL model_trap actual=%b expected=%b t=%0t", trap, m.trp, $time);
            end
            if (fetch_count !== m.cnt) begin
                errors++; $display("FAIL model_count actual=%h expected=%h t=%0t", fetch_count, m.cnt, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic st, input logic hr, input logic rdy,
                       input logic jv, input logic [15:0] ja);
        start = st; halt_req = hr; addr_ready = rdy; jump_valid = jv; jump_addr = ja;
        @(posedge clk);
        #1;
        start = 1'b0; halt_req = 1'b0; addr_ready = 1'b0; jump_valid = 1'b0;
    endtask

    task automatic async_reset_check();
        #2 rst = 1'b1;
        #1;
        chk("rst_addr",  {16'h0, addr}, 32'h0);
        chk("rst_valid", {31'h0, addr_valid}, 32'h0);
        chk("rst_run",   {31'h0, running}, 32'h0);
        chk("rst_trap",  {31'h0, trap}, 32'h0);
        chk("rst_count", {16'h0, fetch_count}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        logic [15:0] ja;
        #12 rst = 1'b0;
        chk("reset_valid", {31'h0, addr_valid}, 32'h0);
        chk("reset_addr",  {16'h0, addr}, 32'h0);

        cyc(1, 0, 0, 0, 16'h0);
        chk("start_valid", {31'h0, addr_valid}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("stream_addr", {16'h0, addr}, 32'(i));
            cyc(0, 0, 1, 0, 16'h0);
        end
        chk("count_after4", {16'h0, fetch_count}, 32'd4);
        cyc(0, 0, 1, 0, 16'h0);
        chk("addr_5", {16'h0, addr}, 32'h5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 16'h0);
        chk("stall_addr",  {16'h0, addr}, 32'h5);
        chk("stall_count", {16'h0, fetch_count}, 32'd5);
        cyc(0, 0, 1, 0, 16'h0);
        chk("resume_addr", {16'h0, addr}, 32'h6);

        cyc(0, 0, 0, 1, 16'h0002);
        chk("jump_noacc_count", {16'h0, fetch_count}, 32'd6);
        cyc(0, 0, 1, 1, 16'h1234);
        chk("jump_acc_addr",  {16'h0, addr}, 32'h1234);
        chk("jump_acc_count", {16'h0, fetch_count}, 32'd7);
        cyc(0, 1, 0, 0, 16'h0);
        chk("halt_valid", {31'h0, addr_valid}, 32'h0);
        cyc(1, 0, 0, 0, 16'h0);
        chk("restart_valid", {31'h0, addr_valid}, 32'h1);
        cyc(0, 0, 1, 0, 16'h0);
        chk("restart_addr", {16'h0, addr}, 32'h1235);

        cyc(0, 0, 0, 1, 16'hFFFF);
        cyc(0, 0, 1, 0, 16'h0);
        chk("wrap_ffff", {16'h0, addr}, 32'h0000);

        cyc(0, 0, 0, 1, 16'h7FFE);
        cyc(0, 0, 1, 0, 16'h0);
        chk("ovf_7fff", {16'h0, addr}, 32'h7FFF);
        cyc(0, 0, 1, 0, 16'h0);
        if (TRAP_EN) begin
            chk("trap_set",   {31'h0, trap}, 32'h1);
            chk("trap_addr",  {16'h0, addr}, 32'h7FFF);
            chk("trap_valid", {31'h0, addr_valid}, 32'h0);
            cyc(1, 0, 0, 0, 16'h0);
            chk("trap_start_ignored", {31'h0, addr_valid}, 32'h0);
        end else begin
            chk("no_trap",   {31'h0, trap}, 32'h0);
            chk("addr_8000", {16'h0, addr}, 32'h8000);
        end

        async_reset_check();

        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 4))
                0:       ja = 16'h7FFD + 16'($urandom_range(0, 2));
                1:       ja = 16'hFFFE + 16'($urandom_range(0, 1));
                default: ja = 16'($urandom);
            endcase
            cyc(($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), ja);
            if (r == 0 && ($urandom_range(0, 3) == 0)) async_reset_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
